// File: rtl/sap_pkg.sv
// Shared definitions for the SAP 16-word RAM: FSM state encoding and default geometry.
package sap_pkg;

  localparam int SAP_ADDR_W = 4;
  localparam int SAP_DATA_W = 8;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    READ  = 2'd2,
    WRITE = 2'd3
  } sap_state_e;

endpackage

// File: rtl/sap_ram_array.sv
// Single-port storage with synchronous write and registered read data.
// Optional SAP_RAM_PARITY_EN stores an even-parity bit alongside each word.
module sap_ram_array
  import sap_pkg::*;
#(
  parameter int ADDR_W = SAP_ADDR_W,
  parameter int DATA_W = SAP_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              par_err
);

`ifdef SAP_RAM_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif

  logic [WORD_W-1:0] mem [2**ADDR_W];
  logic [WORD_W-1:0] wword;
  logic [DATA_W-1:0] rdata_d, rdata_q;

  // A healthy stored word (data plus parity bit) always XOR-reduces to zero.
  always_comb begin
`ifdef SAP_RAM_PARITY_EN
    wword   = {^wdata, wdata};
    par_err = ^mem[addr];
`else
    wword   = wdata;
    par_err = 1'b0;
`endif
    rdata_d = re ? mem[addr][DATA_W-1:0] : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wword;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sap_ram16.sv
// SAP RAM controller: clears every word after reset, then serves single-cycle
// read/write requests. Build with SAP_RAM_PARITY_EN to add per-word parity checking.
module sap_ram16
  import sap_pkg::*;
#(
  parameter int ADDR_W = SAP_ADDR_W,
  parameter int DATA_W = SAP_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              we,
  input  logic              re,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              busy,
  output logic              err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  sap_state_e        state_q, state_d;
  logic [ADDR_W-1:0] sweep_cnt_q, sweep_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rvalid_q, rvalid_d;
  logic              err_q, err_d;

  logic              mem_we, mem_re, par_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  always_comb begin
    state_d     = state_q;
    sweep_cnt_d = sweep_cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rvalid_d    = 1'b0;
    err_d       = err_q;
    case (state_q)
      CLEAR: begin
        if (sweep_cnt_q == LAST_ADDR) begin
          state_d = IDLE;
        end else begin
          sweep_cnt_d = sweep_cnt_q + ADDR_W'(1);
        end
      end
      IDLE: begin
        // A simultaneous read is dropped in favour of the write and flagged.
        if (we) begin
          addr_d  = addr;
          wdata_d = wdata;
          state_d = WRITE;
          if (re) begin
            err_d = 1'b1;
          end
        end else if (re) begin
          addr_d  = addr;
          state_d = READ;
        end
      end
      READ: begin
        rvalid_d = 1'b1;
        state_d  = IDLE;
        if (par_err) begin
          err_d = 1'b1;
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= CLEAR;
      sweep_cnt_q <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rvalid_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_cnt_q <= sweep_cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rvalid_q    <= rvalid_d;
      err_q       <= err_d;
    end
  end

  // Array accesses are suppressed on a reset edge so an in-flight write is aborted.
  assign mem_we    = rst_n && (state_q == CLEAR || state_q == WRITE);
  assign mem_re    = rst_n && (state_q == READ);
  assign mem_addr  = (state_q == CLEAR) ? sweep_cnt_q : addr_q;
  assign mem_wdata = (state_q == CLEAR) ? '0 : wdata_q;

  sap_ram_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_array (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (mem_we),
    .re     (mem_re),
    .addr   (mem_addr),
    .wdata  (mem_wdata),
    .rdata  (rdata),
    .par_err(par_err)
  );

  assign rvalid = rvalid_q;
  assign busy   = (state_q != IDLE);
  assign err    = err_q;

endmodule

// File: tb/tb_sap_ram16.sv
// Directed self-checking bench for sap_ram16 (default 16 x 8 geometry).
module tb_sap_ram16;

  logic       clk;
  logic       rst_n;
  logic [3:0] addr;
  logic [7:0] wdata;
  logic       we;
  logic       re;
  logic [7:0] rdata;
  logic       rvalid;
  logic       busy;
  logic       err;

  int tests_run;
  int tests_failed;

  sap_ram16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .addr  (addr),
    .wdata (wdata),
    .we    (we),
    .re    (re),
    .rdata (rdata),
    .rvalid(rvalid),
    .busy  (busy),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    tick();
    we = 1'b0;
    tick();
  endtask

  // Returns rvalid after the request edge, after the data edge and one cycle later.
  task automatic do_read(input logic [3:0] a, output logic v_early, output logic v_data,
                         output logic [7:0] d, output logic v_late);
    addr = a;
    re   = 1'b1;
    tick();
    re      = 1'b0;
    v_early = rvalid;
    tick();
    v_data = rvalid;
    d      = rdata;
    tick();
    v_late = rvalid;
  endtask

  task automatic count_busy(output int n, output int pulses);
    n      = 0;
    pulses = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      if (rvalid === 1'b1) pulses++;
      tick();
    end
  endtask

  task automatic test_reset();
    int n, p;
    rst_n = 1'b0;
    we    = 1'b0;
    re    = 1'b0;
    addr  = '0;
    wdata = '0;
    repeat (3) tick();
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b expected 1", busy); end
    tests_run++; if (rvalid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_rvalid: got %b expected 0", rvalid); end
    tests_run++; if (rdata !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_rdata: got %h expected 00", rdata); end
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
    rst_n = 1'b1;
    count_busy(n, p);
    tests_run++; if (n != 16) begin tests_failed++; $display("[TB] FAIL reset_busy_cycles: got %0d expected 16", n); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_clear_readback();
    logic ve, vd, vl;
    logic [7:0] d;
    for (int i = 0; i < 16; i++) begin
      do_read(4'(i), ve, vd, d, vl);
      tests_run++;
      if (ve !== 1'b0 || vd !== 1'b1 || d !== 8'h00 || vl !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL clear_read[%0d]: got rvalid=%b%b%b rdata=%h expected rvalid=010 rdata=00", i, ve, vd, vl, d);
      end
    end
  endtask

  task automatic test_write_read();
    logic ve, vd, vl;
    logic [7:0] d;
    logic [3:0] wa [5];
    logic [7:0] wd [5];
    wa = '{4'h0, 4'hF, 4'h5, 4'h6, 4'hA};
    wd = '{8'h01, 8'h80, 8'hA5, 8'h5A, 8'h5C};
    addr  = 4'hA;
    wdata = 8'h5C;
    we    = 1'b1;
    tick();
    we = 1'b0;
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL write_busy: got %b expected 1", busy); end
    tick();
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL write_done_busy: got %b expected 0", busy); end
    do_read(4'hA, ve, vd, d, vl);
    tests_run++; if (ve !== 1'b0) begin tests_failed++; $display("[TB] FAIL raw_early_rvalid: got %b expected 0", ve); end
    tests_run++; if (vd !== 1'b1) begin tests_failed++; $display("[TB] FAIL raw_rvalid: got %b expected 1", vd); end
    tests_run++; if (d !== 8'h5C) begin tests_failed++; $display("[TB] FAIL raw_rdata: got %h expected 5c", d); end
    tests_run++; if (vl !== 1'b0) begin tests_failed++; $display("[TB] FAIL raw_late_rvalid: got %b expected 0", vl); end
    for (int i = 0; i < 4; i++) do_write(wa[i], wd[i]);
    for (int i = 0; i < 5; i++) begin
      do_read(wa[i], ve, vd, d, vl);
      tests_run++;
      if (vd !== 1'b1 || d !== wd[i]) begin
        tests_failed++;
        $display("[TB] FAIL pattern_read[%h]: got rvalid=%b rdata=%h expected rvalid=1 rdata=%h", wa[i], vd, d, wd[i]);
      end
    end
    repeat (3) tick();
    do_write(4'h9, 8'h11);
    tests_run++; if (rdata !== 8'h5C) begin tests_failed++; $display("[TB] FAIL rdata_hold: got %h expected 5c", rdata); end
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("[TB] FAIL err_clean: got %b expected 0", err); end
  endtask

  task automatic test_busy_ignore();
    logic ve, vd, vl;
    logic [7:0] d;
    int pulses;
    pulses = 0;
    addr  = 4'h2;
    wdata = 8'h33;
    we    = 1'b1;
    tick();
    we = 1'b0;
    re = 1'b1;
    tick();
    re = 1'b0;
    if (rvalid === 1'b1) pulses++;
    repeat (3) begin
      tick();
      if (rvalid === 1'b1) pulses++;
    end
    tests_run++; if (pulses != 0) begin tests_failed++; $display("[TB] FAIL busy_ignore_rvalid: got %0d pulses expected 0", pulses); end
    tests_run++; if (err !== 1'b0) begin tests_failed++; $display("[TB] FAIL busy_ignore_err: got %b expected 0", err); end
    tests_run++; if (rdata !== 8'h5C) begin tests_failed++; $display("[TB] FAIL busy_ignore_rdata: got %h expected 5c", rdata); end
    do_read(4'h2, ve, vd, d, vl);
    tests_run++; if (vd !== 1'b1 || d !== 8'h33) begin tests_failed++; $display("[TB] FAIL busy_ignore_write: got rvalid=%b rdata=%h expected 1/33", vd, d); end
  endtask

  task automatic test_parity();
    logic ve, vd, vl;
    logic [7:0] d;
    logic exp_err;
    do_write(4'h1, 8'h77);
`ifdef SAP_RAM_PARITY_EN
    dut.u_array.mem[1][8] = ~dut.u_array.mem[1][8];
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    do_read(4'h1, ve, vd, d, vl);
    tests_run++; if (vd !== 1'b1 || d !== 8'h77) begin tests_failed++; $display("[TB] FAIL parity_data: got rvalid=%b rdata=%h expected 1/77", vd, d); end
    tests_run++; if (err !== exp_err) begin tests_failed++; $display("[TB] FAIL parity_err: got %b expected %b", err, exp_err); end
  endtask

  task automatic test_collision();
    logic ve, vd, vl;
    logic [7:0] d;
    int pulses;
    pulses = 0;
    addr  = 4'h3;
    wdata = 8'hFF;
    we    = 1'b1;
    re    = 1'b1;
    tick();
    we = 1'b0;
    re = 1'b0;
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL collision_busy: got %b expected 1", busy); end
    repeat (3) begin
      if (rvalid === 1'b1) pulses++;
      tick();
    end
    tests_run++; if (pulses != 0) begin tests_failed++; $display("[TB] FAIL collision_rvalid: got %0d pulses expected 0", pulses); end
    tests_run++; if (err !== 1'b1) begin tests_failed++; $display("[TB] FAIL collision_err: got %b expected 1", err); end
    do_read(4'h3, ve, vd, d, vl);
    tests_run++; if (vd !== 1'b1 || d !== 8'hFF) begin tests_failed++; $display("[TB] FAIL collision_write: got rvalid=%b rdata=%h expected 1/ff", vd, d); end
    do_write(4'h4, 8'h10);
    repeat (4) tick();
    tests_run++; if (err !== 1'b1) begin tests_failed++; $display("[TB] FAIL err_sticky: got %b expected 1", err); end
  endtask

  task automatic test_reset_midway();
    logic ve, vd, vl;
    logic [7:0] d;
    int n, p;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (7) tick();
    rst_n = 1'b0;
    tick();
    tests_run++; if (busy !== 1'b1 || err !== 1'b0 || rvalid !== 1'b0) begin tests_failed++; $display("[TB] FAIL midclear_reset: got busy=%b err=%b rvalid=%b expected 1/0/0", busy, err, rvalid); end
    rst_n = 1'b1;
    count_busy(n, p);
    tests_run++; if (n != 16 || p != 0) begin tests_failed++; $display("[TB] FAIL midclear_restart: got %0d busy cycles %0d pulses expected 16/0", n, p); end
    do_read(4'hF, ve, vd, d, vl);
    tests_run++; if (vd !== 1'b1 || d !== 8'h00) begin tests_failed++; $display("[TB] FAIL midclear_wordF: got rvalid=%b rdata=%h expected 1/00", vd, d); end
    do_read(4'h9, ve, vd, d, vl);
    tests_run++; if (vd !== 1'b1 || d !== 8'h00) begin tests_failed++; $display("[TB] FAIL midclear_word9: got rvalid=%b rdata=%h expected 1/00", vd, d); end
    do_write(4'h6, 8'h42);
    addr = 4'h6;
    re   = 1'b1;
    tick();
    re    = 1'b0;
    rst_n = 1'b0;
    tick();
    tests_run++; if (rvalid !== 1'b0 || rdata !== 8'h00) begin tests_failed++; $display("[TB] FAIL midread_reset: got rvalid=%b rdata=%h expected 0/00", rvalid, rdata); end
    rst_n = 1'b1;
    count_busy(n, p);
    tests_run++; if (n != 16 || p != 0) begin tests_failed++; $display("[TB] FAIL midread_restart: got %0d busy cycles %0d pulses expected 16/0", n, p); end
    do_read(4'h6, ve, vd, d, vl);
    tests_run++; if (vd !== 1'b1 || d !== 8'h00) begin tests_failed++; $display("[TB] FAIL midread_word6: got rvalid=%b rdata=%h expected 1/00", vd, d); end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_clear_readback();
    test_write_read();
    test_busy_ignore();
    test_parity();
    test_collision();
    test_reset_midway();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sap_ram16.md
SAP_RAM16 -- requirements
Module: sap_ram16

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, meaning address width (depth = 2**ADDR_W words).
REQ-002 SHALL have parameter DATA_W, default 8, meaning word width.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-005 SHALL have port addr  input  ADDR_W  word address, driven by the upstream memory address register output.
REQ-006 SHALL have port wdata  input  DATA_W  write data.
REQ-007 SHALL have port we  input  1  write request, sampled in IDLE only.
REQ-008 SHALL have port re  input  1  read request, sampled in IDLE only.
REQ-009 SHALL have port rdata  output  DATA_W  registered read data.
REQ-010 SHALL have port rvalid  output  1  one-cycle pulse when rdata is updated.
REQ-011 SHALL have port busy  output  1  high when requests are ignored.
REQ-012 SHALL have port err  output  1  sticky collision / parity error flag.

Function
REQ-013 SHALL implement FSM states CLEAR, IDLE, READ, WRITE.
REQ-014 CLEAR: write 0 to address sweep_cnt each cycle, sweep_cnt 0 -> 2**ADDR_W-1, then IDLE; busy=1 throughout (16 cycles at default).
REQ-015 IDLE, we=1: latch addr/wdata, go WRITE; the array is written at the WRITE-state edge; return to IDLE next cycle.
REQ-016 IDLE, re=1, we=0: latch addr, go READ; rdata <= mem[addr], rvalid=1 for exactly one cycle in the cycle after READ (read latency 2 clocks from request edge).
REQ-017 IDLE, we=1 and re=1 simultaneously: write wins, read is dropped, err set to 1.
REQ-018 busy SHALL be 1 in CLEAR, READ, WRITE and 0 in IDLE; we/re while busy are ignored without error.
REQ-019 rdata SHALL hold its last value until the next completed read.
REQ-020 Address arithmetic: sweep_cnt SHALL be ADDR_W bits; no wrap beyond the last address (exit on terminal count).
REQ-021 Read-after-write to the same address SHALL return the newly written data.
REQ-022 err SHALL clear only on reset.

Reset
REQ-023 rst_n=0 at any clock edge, including mid-CLEAR/READ/WRITE, SHALL enter CLEAR with sweep_cnt=0, abort pending access.
REQ-024 Reset values: rdata=0, rvalid=0, busy=1, err=0.
REQ-025 After rst_n rises, busy SHALL stay 1 for 2**ADDR_W cycles, then IDLE with all words 0.

Configuration
REQ-026 Macro SAP_RAM_PARITY_EN: when defined, each word SHALL store an extra even-parity bit computed on write; a read whose stored parity mismatches SHALL set err and still deliver data.
REQ-027 Without SAP_RAM_PARITY_EN: no parity storage; err set only by REQ-017 collisions.

Structure
REQ-028 Shared package sap_pkg SHALL hold the FSM state enum (CLEAR, IDLE, READ, WRITE) and default constants SAP_ADDR_W=4, SAP_DATA_W=8.
REQ-029 Storage SHALL be a sub-module sap_ram_array (single-port, sync write, sync read); FSM and control in sap_ram16.

Verification
REQ-030 Reset then release: busy=1 for 16 cycles then 0; read of every address 0..15 returns 0x00 with one rvalid pulse each.
REQ-031 Write addr=0xA data=0x5C, then read addr=0xA -> rdata=0x5C, rvalid one cycle, 2-cycle latency.
REQ-032 we=1,re=1 at addr=0x3 data=0xFF in IDLE -> mem[3]=0xFF, no rvalid, err=1 until reset.
REQ-033 re pulsed while busy=1 (during WRITE) -> ignored, no rvalid, err stays 0.
REQ-034 Assert rst_n=0 in the middle of CLEAR (cycle 7) and in READ -> rvalid never pulses, CLEAR restarts, 16 busy cycles after release.
REQ-035 With SAP_RAM_PARITY_EN, force a stored parity bit flip at addr=0x1 and read it -> err=1, rdata delivered; without macro, same read leaves err=0.
